// File: rtl/dsa_pkg.sv
// Shared constants for the digit-serial adder: FSM encoding, slice width and
// the slice-counter width helper.
package dsa_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int SLICE_W = 2;

  // Counter must index WIDTH/SLICE_W slices; keep at least one bit for WIDTH=2.
  function automatic int count_width(input int width);
    int n;
    n = $clog2(width / SLICE_W);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/csel_slice_2bit.sv
// Combinational carry-select slice: precomputes both carry-in cases and lets
// the registered carry pick the result through the 2-bit mux.
module csel_slice_2bit
  import dsa_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               carry_in,
  output logic [SLICE_W-1:0] sum,
  output logic               carry_out
);

  logic [SLICE_W:0] sum0;
  logic [SLICE_W:0] sum1;

  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, 1'b1};

  multiplexer_2bit u_mux (
    .d0         (sum0[SLICE_W-1:0]),
    .d1         (sum1[SLICE_W-1:0]),
    .Select_bit (carry_in),
    .y          (sum)
  );

  assign carry_out = carry_in ? sum1[SLICE_W] : sum0[SLICE_W];

endmodule

// File: rtl/multiplexer_2bit.sv
// Two-input, 2-bit wide multiplexer; Select_bit=1 picks d1.
module multiplexer_2bit (
  input  logic [1:0] d0,
  input  logic [1:0] d1,
  input  logic       Select_bit,
  output logic [1:0] y
);

  assign y = Select_bit ? d1 : d0;

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial WIDTH-bit adder, one 2-bit carry-select slice per clock, LSB first.
// Optional signed-overflow output Ovf is built only when DSA_OVERFLOW_EN is defined.
module digit_serial_adder
  import dsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef DSA_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CNT_W = count_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(WIDTH / SLICE_W - 1);

  generate
    if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
      $error("digit_serial_adder: WIDTH must be even and >= 2");
    end
  endgenerate

  logic [1:0]         state_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               carry_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   s_reg;
  logic               cout_reg;

  logic               accept;
  logic               last_slice;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_carry;

  // start is honoured only outside RUN, which also gives back-to-back from DONE.
  assign accept     = start && (state_reg == IDLE || state_reg == DONE);
  assign last_slice = (count_reg == LAST_SLICE);

  assign slice_a = a_reg[count_reg * SLICE_W +: SLICE_W];
  assign slice_b = b_reg[count_reg * SLICE_W +: SLICE_W];

  csel_slice_2bit u_slice (
    .a         (slice_a),
    .b         (slice_b),
    .carry_in  (carry_reg),
    .sum       (slice_sum),
    .carry_out (slice_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          s_reg[count_reg * SLICE_W +: SLICE_W] <= slice_sum;
          carry_reg <= slice_carry;
          if (last_slice) begin
            cout_reg  <= slice_carry;
            state_reg <= DONE;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        IDLE, DONE: begin
          if (accept) begin
            a_reg     <= A;
            b_reg     <= B;
            carry_reg <= Cin;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            count_reg <= '0;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef DSA_OVERFLOW_EN
  logic ovf_reg;

  // Evaluated on the final slice so Ovf is valid together with done; the new
  // MSB of S is the high bit of that last slice sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (accept) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == RUN && last_slice) begin
      ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                 (slice_sum[SLICE_W-1] != a_reg[WIDTH-1]);
    end
  end

  assign Ovf = ovf_reg;
`endif

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign S    = s_reg;
  assign Cout = cout_reg;

endmodule
